// File: rtl/exec_muldiv_iter_pkg.sv
// Shared types and constants for the iterative M-extension unit (exec_muldiv_iter).
package exec_pkg;

    localparam int MULDIV_XLEN_DEFAULT = 64;
    localparam int MULDIV_WORD_N       = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/exec_muldiv_iter_signfix.sv
// Combinational sign helper: optional 32-bit extension on entry, conditional negate,
// and 32-bit sign extension of the result for word ops.
module muldiv_signfix #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] val,
    input  logic            is_signed,
    input  logic            force_neg,
    input  logic            word,
    output logic [XLEN-1:0] ext,
    output logic            neg,
    output logic [XLEN-1:0] res
);
    localparam int SH = XLEN - 32;

    logic [XLEN-1:0] val_up;
    logic [XLEN-1:0] neg_val;
    logic [XLEN-1:0] neg_up;

    assign val_up = val << SH;

    // Word entry: keep bits [31:0], extend with the sign only for signed operands.
    always_comb begin
        ext = val;
        if (word) begin
            if (is_signed) ext = $signed(val_up) >>> SH;
            else           ext = val_up >> SH;
        end
    end

    assign neg     = force_neg | (is_signed & ext[XLEN-1]);
    assign neg_val = neg ? (~ext + 1'b1) : ext;
    assign neg_up  = neg_val << SH;
    assign res     = word ? ($signed(neg_up) >>> SH) : neg_val;

endmodule

// File: rtl/exec_muldiv_iter.sv
// Iterative MUL/DIV unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional *W word ops are enabled by defining MULDIV_WORD_OPS_EN (XLEN=64 only).
module exec_muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN_DEFAULT,
    parameter int RD_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_e      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            busy
);
    localparam int CNT_W = $clog2(XLEN + 1);

    muldiv_state_e     state;
    muldiv_op_e        op_q;
    logic              word_q;
    logic [RD_W-1:0]   rd_q;
    logic              res_neg;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    logic word_in;
`ifdef MULDIV_WORD_OPS_EN
    assign word_in = in_word;
`else
    logic unused_word;
    assign unused_word = in_word;
    assign word_in     = 1'b0;
`endif

    // Operand decode
    logic in_s1, in_s2, in_is_div, in_is_rem;
    assign in_s1     = in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign in_s2     = in_op inside {OP_MULH, OP_DIV, OP_REM};
    assign in_is_div = in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign in_is_rem = in_op inside {OP_REM, OP_REMU};

    logic [XLEN-1:0] a_ext, a_mag, b_ext, b_mag;
    logic            a_neg, b_neg;

    muldiv_signfix #(.XLEN(XLEN)) u_fix_a (
        .val(in_rs1), .is_signed(in_s1), .force_neg(1'b0), .word(word_in),
        .ext(a_ext), .neg(a_neg), .res(a_mag)
    );

    muldiv_signfix #(.XLEN(XLEN)) u_fix_b (
        .val(in_rs2), .is_signed(in_s2), .force_neg(1'b0), .word(word_in),
        .ext(b_ext), .neg(b_neg), .res(b_mag)
    );

    // Special cases bypass iteration; compared on the (possibly word-extended) operands.
    logic [XLEN-1:0] min_neg;
    logic            div_zero, div_ovf;
    assign min_neg  = {XLEN{1'b1}} << (word_in ? MULDIV_WORD_N - 1 : XLEN - 1);
    assign div_zero = in_is_div && (b_ext == '0);
    assign div_ovf  = (in_op inside {OP_DIV, OP_REM}) && (a_ext == min_neg) && (b_ext == '1);

    logic [CNT_W-1:0] last_cnt;
    assign last_cnt = word_q ? CNT_W'(MULDIV_WORD_N - 1) : CNT_W'(XLEN - 1);

    logic [XLEN:0] rem_sh, diff;
    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    // High-half negate: -P keeps ~hi unless the low half is zero, where the carry ripples up.
    logic [XLEN-1:0] raw;
    logic            hi_ones, fix_neg;
    always_comb begin
        raw     = quo;
        fix_neg = res_neg;
        hi_ones = 1'b0;
        case (op_q)
            OP_MUL: raw = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: begin
                hi_ones = res_neg && (prod[XLEN-1:0] != '0);
                raw     = hi_ones ? ~prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
                fix_neg = res_neg && !hi_ones;
            end
            OP_REM, OP_REMU: raw = rem;
            default: raw = quo;
        endcase
    end

    logic [XLEN-1:0] fix_res;
    logic [XLEN-1:0] unused_x_ext;
    logic            unused_x_neg;

    muldiv_signfix #(.XLEN(XLEN)) u_fix_out (
        .val(raw), .is_signed(1'b0), .force_neg(fix_neg), .word(word_q),
        .ext(unused_x_ext), .neg(unused_x_neg), .res(fix_res)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            op_q       <= OP_MUL;
            word_q     <= 1'b0;
            rd_q       <= '0;
            res_neg    <= 1'b0;
            cnt        <= '0;
            mcand      <= '0;
            prod       <= '0;
            mplier     <= '0;
            divisor    <= '0;
            quo        <= '0;
            rem        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready && !flush) begin
                        in_ready <= 1'b0;
                        op_q     <= in_op;
                        word_q   <= word_in;
                        rd_q     <= in_rd;
                        cnt      <= '0;
                        mcand    <= {{XLEN{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        prod     <= '0;
                        divisor  <= b_mag;
                        // Word dividends are left-aligned so 32 steps consume all their bits.
                        quo      <= word_in ? (a_mag << MULDIV_WORD_N) : a_mag;
                        rem      <= '0;
                        res_neg  <= in_is_rem ? a_neg : (a_neg ^ b_neg);
                        if (div_zero || div_ovf) begin
                            state   <= S_DONE;
                            res_neg <= 1'b0;
                            quo     <= div_zero ? '1 : a_ext;
                            rem     <= div_zero ? a_ext : '0;
                        end else begin
                            state <= in_is_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == last_cnt) state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        if (!diff[XLEN]) begin
                            rem <= diff[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == last_cnt) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end else if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_result <= fix_res;
                        out_rd     <= rd_q;
                    end else if (out_ready) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv_iter.sv
// Directed bench for exec_muldiv_iter (XLEN=64); word-op checks follow MULDIV_WORD_OPS_EN.
module tb_exec_muldiv_iter;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    muldiv_op_e  in_op = OP_MUL;
    logic        in_word = 1'b0;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;
    logic [5:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic [5:0]  out_rd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    exec_muldiv_iter #(.XLEN(64), .RD_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issues one op and waits (bounded) for out_valid; called at posedge+1.
    task automatic run_op(input muldiv_op_e op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [5:0] rd,
                          output logic [63:0] res, output logic [5:0] ord, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        in_op = op; in_word = word; in_rs1 = a; in_rs2 = b; in_rd = rd; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        res = out_result;
        ord = out_rd;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000", {in_ready, out_valid, busy});
        end
        checks++;
        if ({out_result, out_rd} !== 70'd0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0/0", out_result, out_rd);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL release got ready/busy %b exp 10", {in_ready, busy});
        end
    endtask

    // Table-driven op runner shared by the multiply / divide / special-case tests.
    task automatic run_table(input string name, input muldiv_op_e ops[4], input logic [63:0] a[4],
                             input logic [63:0] b[4], input logic [63:0] exp_r[4], input int exp_lat);
        logic [63:0] res;
        logic [5:0]  ord;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 1'b0, a[i], b[i], 6'(i + 10), res, ord, lat);
            checks++;
            if (res !== exp_r[i]) begin
                errors++; $display("FAIL %s[%0d] result got %h exp %h", name, i, res, exp_r[i]);
            end
            checks++;
            if (lat !== exp_lat || ord !== 6'(i + 10)) begin
                errors++;
                $display("FAIL %s[%0d] lat/rd got %0d/%0d exp %0d/%0d", name, i, lat, ord, exp_lat, i + 10);
            end
            retire();
            checks++;
            if ({in_ready, out_valid, busy} !== 3'b100) begin
                errors++; $display("FAIL %s[%0d] retire got %b exp 100", name, i, {in_ready, out_valid, busy});
            end
        end
    endtask

    task automatic test_mul();
        muldiv_op_e  ops[4] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU};
        logic [63:0] a[4]   = '{64'd7, '1, '1, '1};
        logic [63:0] b[4]   = '{64'hFFFF_FFFF_FFFF_FFFD, '1, '1, '1};
        logic [63:0] e[4]   = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, '1};
        run_table("mul", ops, a, b, e, 65);
    endtask

    task automatic test_div();
        muldiv_op_e  ops[4] = '{OP_DIV, OP_REM, OP_REMU, OP_DIVU};
        logic [63:0] a[4]   = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd13, 64'd100};
        logic [63:0] b[4]   = '{64'd2, 64'd2, 64'd4, 64'd7};
        logic [63:0] e[4]   = '{64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd1, 64'd14};
        run_table("div", ops, a, b, e, 65);
    endtask

    task automatic test_special();
        muldiv_op_e  ops[4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
        logic [63:0] a[4]   = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] b[4]   = '{64'd0, 64'd0, '1, '1};
        logic [63:0] e[4]   = '{'1, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
        run_table("special", ops, a, b, e, 1);
    endtask

    task automatic test_backpressure();
        logic [63:0] res;
        logic [5:0]  ord;
        int          lat;
        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 6'd9, res, ord, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, busy, out_rd, out_result} !== {3'b101, 6'd9, 64'd14}) begin
                errors++;
                $display("FAIL hold[%0d] got v%b r%b rd%0d res %h exp v1 r0 rd9 res e",
                         i, out_valid, in_ready, out_rd, out_result);
            end
        end
        retire();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL hold_retire got %b exp 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_flush();
        logic        seen;
        logic [63:0] res;
        logic [5:0]  ord;
        int          lat;
        in_op = OP_DIV; in_word = 1'b0; in_rs1 = 64'd1000; in_rs2 = 64'd3; in_rd = 6'd3;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++; $display("FAIL flush got rdy/busy/vld %b exp 100", {in_ready, busy, out_valid});
        end
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; seen |= out_valid; end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flush_drop got out_valid %b exp 0", seen);
        end
        // Flush beats a simultaneous offer in IDLE.
        in_op = OP_MUL; in_rs1 = 64'd2; in_rs2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_idle got busy/rdy %b exp 01", {busy, in_ready});
        end
        run_op(OP_MUL, 1'b0, 64'd6, 64'd7, 6'd4, res, ord, lat);
        checks++;
        if ({res, ord} !== {64'd42, 6'd4} || lat !== 65) begin
            errors++; $display("FAIL after_flush got %h/%0d lat %0d exp 2a/4 lat 65", res, ord, lat);
        end
        retire();
    endtask

    task automatic test_reset_midop();
        logic seen;
        in_op = OP_MUL; in_word = 1'b0; in_rs1 = 64'd9; in_rs2 = 64'd9; in_rd = 6'd1;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b000) begin
            errors++; $display("FAIL midop_reset got %b exp 000", {busy, out_valid, in_ready});
        end
        @(posedge clk); #1 reset = 1'b1;
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; seen |= out_valid; end
        checks++;
        if ({seen, in_ready} !== 2'b01) begin
            errors++; $display("FAIL midop_after got vld/rdy %b exp 01", {seen, in_ready});
        end
    endtask

    task automatic test_word();
        logic [63:0] res;
        logic [5:0]  ord;
        int          lat;
`ifdef MULDIV_WORD_OPS_EN
        run_op(OP_DIV, 1'b1, 64'h0000_0001_8000_0000, '1, 6'd2, res, ord, lat);
        checks++;
        if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== 1) begin
            errors++; $display("FAIL divw_ovf got %h lat %0d exp ffffffff80000000 lat 1", res, lat);
        end
        retire();
        run_op(OP_MUL, 1'b1, 64'h1_0000, 64'h1_0000, 6'd2, res, ord, lat);
        checks++;
        if (res !== 64'd0 || lat !== 33) begin
            errors++; $display("FAIL mulw got %h lat %0d exp 0 lat 33", res, lat);
        end
        retire();
        run_op(OP_MUL, 1'b1, 64'd3, 64'h0000_0000_FFFF_FFFF, 6'd2, res, ord, lat);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 33) begin
            errors++; $display("FAIL mulw_neg got %h lat %0d exp fffffffffffffffd lat 33", res, lat);
        end
        retire();
        run_op(OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 6'd2, res, ord, lat);
        checks++;
        if (res !== 64'h0000_0000_7FFF_FFFF || lat !== 33) begin
            errors++; $display("FAIL divuw got %h lat %0d exp 7fffffff lat 33", res, lat);
        end
        retire();
`else
        run_op(OP_MUL, 1'b1, 64'h1_0000_0000, 64'd2, 6'd2, res, ord, lat);
        checks++;
        if (res !== 64'h2_0000_0000 || lat !== 65) begin
            errors++; $display("FAIL word_ignored got %h lat %0d exp 200000000 lat 65", res, lat);
        end
        retire();
`endif
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
